// File: rtl/player_a.sv
// player_a: row player for the iterated prisoner's dilemma.
// Win-stay/lose-shift strategy with a punishment burst after repeated
// sucker payoffs, forced defection in the final rounds and a game-over stop.
// Keeps its own saturating payoff score and resolved-round count.
// Optional feature macro: PLAYER_A_FORGIVE_EN (an opponent cooperation during
// PUNISH ends the burst early).
module player_a #(
  parameter int NUM_ROUNDS     = 200,
  parameter int ENDGAME_ROUNDS = 1,
  parameter int PUNISH_LEN     = 3,
  parameter int SCORE_W        = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               round_valid,
  input  logic               action_B,
  output logic               action_A,
  output logic [SCORE_W-1:0] score,
  output logic [15:0]        round_count,
  output logic               game_over
);

  localparam logic [2:0] ST_COOP    = 3'd0;
  localparam logic [2:0] ST_DEFECT  = 3'd1;
  localparam logic [2:0] ST_PUNISH  = 3'd2;
  localparam logic [2:0] ST_ENDGAME = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam logic [16:0] LAST_ROUND    = 17'(NUM_ROUNDS);
  localparam logic [16:0] ENDGAME_START = 17'(NUM_ROUNDS - ENDGAME_ROUNDS);
  localparam logic [3:0]  PUNISH_LOAD   = 4'(PUNISH_LEN);

`ifdef PLAYER_A_FORGIVE_EN
  localparam bit FORGIVE_EN = 1'b1;
`else
  localparam bit FORGIVE_EN = 1'b0;
`endif

  logic [2:0]         state_q, state_d;
  logic [1:0]         sucker_cnt_q, sucker_cnt_d;
  logic [3:0]         punish_cnt_q, punish_cnt_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [15:0]        round_count_q, round_count_d;

  logic               resolve;
  logic [2:0]         payoff;
  logic [SCORE_W:0]   score_sum;
  logic [1:0]         sucker_inc;
  logic [16:0]        next_round;
  logic [2:0]         strat_state;

  // Own move and game-over flag are pure decodes of the state register,
  // so action_A never depends combinationally on action_B.
  assign action_A    = (state_q == ST_DEFECT) || (state_q == ST_PUNISH) ||
                       (state_q == ST_ENDGAME);
  assign game_over   = (state_q == ST_DONE);
  assign score       = score_q;
  assign round_count = round_count_q;

  // Round resolution: payoff, counters, strategy transition and overrides.
  always_comb begin
    // NOTE: every variable gets a hold/default value first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d       = state_q;
    sucker_cnt_d  = sucker_cnt_q;
    punish_cnt_d  = punish_cnt_q;
    score_d       = score_q;
    round_count_d = round_count_q;
    strat_state   = state_q;

    resolve = round_valid && (state_q != ST_DONE);

    case ({action_A, action_B})
      2'b00:   payoff = 3'd3;
      2'b01:   payoff = 3'd0;
      2'b10:   payoff = 3'd5;
      default: payoff = 3'd1;
    endcase

    score_sum  = {1'b0, score_q} + (SCORE_W+1)'(payoff);
    sucker_inc = (sucker_cnt_q == 2'd3) ? 2'd3 : sucker_cnt_q + 2'd1;
    next_round = {1'b0, round_count_q} + 17'd1;

    if (resolve) begin
      score_d       = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
      round_count_d = next_round[15:0];

      // Sucker payoffs are (A=0, B=1); any opponent cooperation clears.
      if (!action_B)      sucker_cnt_d = 2'd0;
      else if (!action_A) sucker_cnt_d = sucker_inc;

      case (state_q)
        ST_COOP: begin
          if (action_B) begin
            if (sucker_inc >= 2'd2) begin
              strat_state  = ST_PUNISH;
              punish_cnt_d = PUNISH_LOAD;
            end else begin
              strat_state = ST_DEFECT;
            end
          end
        end
        ST_DEFECT: begin
          if (action_B) strat_state = ST_COOP;
        end
        ST_PUNISH: begin
          if ((FORGIVE_EN && !action_B) || (punish_cnt_q == 4'd1)) begin
            strat_state  = ST_COOP;
            sucker_cnt_d = 2'd0;
            punish_cnt_d = 4'd0;
          end else begin
            punish_cnt_d = punish_cnt_q - 4'd1;
          end
        end
        default: strat_state = state_q;
      endcase

      // Match-length overrides win over the strategy.
      if (next_round == LAST_ROUND)         state_d = ST_DONE;
      else if (next_round >= ENDGAME_START) state_d = ST_ENDGAME;
      else                                  state_d = strat_state;
    end
  end

  // State registers; reset asserts asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_COOP;
      sucker_cnt_q  <= 2'd0;
      punish_cnt_q  <= 4'd0;
      score_q       <= '0;
      round_count_q <= 16'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, regardless of statement order.
      state_q       <= state_d;
      sucker_cnt_q  <= sucker_cnt_d;
      punish_cnt_q  <= punish_cnt_d;
      score_q       <= score_d;
      round_count_q <= round_count_d;
    end
  end

endmodule

// File: doc/player_a.md
# player_a

Row player for the iterated prisoner's dilemma match. Once per valid round it samples the opponent's move (`action_B`) and drives its own registered move (`action_A`). The strategy is win-stay/lose-shift (Pavlov) with three additions: a punishment burst after repeated sucker payoffs, forced defection in the final rounds, and a game-over stop. It also keeps its own payoff score and round count for the match scoreboard. Move encoding is 0 = cooperate, 1 = defect.

## Interface
- `NUM_ROUNDS`, 200: rounds per game; range 2..65535.
- `ENDGAME_ROUNDS`, 1: number of final rounds forced to defect; must be < `NUM_ROUNDS`.
- `PUNISH_LEN`, 3: length of a punishment burst, in rounds; range 1..15.
- `SCORE_W`, 16: width of the score accumulator.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `round_valid` in 1: a round resolves on each rising edge where this is 1.
- `action_B` in 1: opponent move for the current round; sampled only when `round_valid`=1.
- `action_A` out 1: own move for the current round; registered.
- `score` out `SCORE_W`: accumulated own payoff.
- `round_count` out 16: number of rounds resolved so far.
- `game_over` out 1: 1 once `NUM_ROUNDS` rounds have resolved.

## Operation
- States and `action_A` per state:
  - COOP → 0
  - DEFECT → 1
  - PUNISH → 1
  - ENDGAME → 1
  - DONE → 0
- `action_A` is decoded from the state register.
- Internal counters:
  - `sucker_cnt`: 2 bits, saturating. Increments on payoff (A=0, B=1). Clears when B=0 or on PUNISH exit.
  - `punish_cnt`: 4 bits.
- Payoff for each (A,B) pair is added to `score`, saturating at all-ones:
  - (0,0) → 3
  - (0,1) → 0
  - (1,0) → 5
  - (1,1) → 1
- Transitions evaluated on each resolved round:
  - COOP, B=0 → COOP.
  - COOP, B=1:
    - If the incremented `sucker_cnt` ≥ 2 → PUNISH, with `punish_cnt` loaded to `PUNISH_LEN`.
    - Otherwise → DEFECT.
  - DEFECT, B=0 (win) → DEFECT. DEFECT, B=1 (lose) → COOP.
  - PUNISH: `action_B` is ignored for state purposes (payoff still scored). `punish_cnt` decrements. When the round resolves with `punish_cnt`=1 → COOP and `sucker_cnt` clears.
  - ENDGAME → ENDGAME until DONE.
- Override priority, using r = `round_count`+1 after the resolve:
  - DONE if r == `NUM_ROUNDS`;
  - else ENDGAME if r ≥ `NUM_ROUNDS`−`ENDGAME_ROUNDS`;
  - else the strategy transition above.
- DONE is absorbing until reset.
  - `round_valid` is ignored in DONE: no score, count, or state change.
  - `game_over`=1 in DONE.
- Reset values: state COOP, `action_A`=0, `score`=0, `round_count`=0, `game_over`=0, `sucker_cnt`=0, `punish_cnt`=0.

## Timing
- Round k occupies the cycles up to and including its resolving edge.
  - `action_A` is stable for the whole round.
  - `action_B` must be stable at the resolving edge.
- At the resolving edge, all of the following update together: `score` (including round k's payoff), `round_count`, state, `action_A` for round k+1, and `game_over`. Latency is 1 cycle from edge to outputs.
- `round_valid`=0: every register holds its value.
- `round_valid` may stay high on consecutive cycles; each such cycle is one round.
- Reset asserted at any time forces all outputs to their reset values immediately, without a clock edge. Release is synchronous to `clk` by design convention; the first round can resolve on the first edge after release.
- No combinational path from `action_B` to `action_A`.

## Configuration
- Macro `PLAYER_A_FORGIVE_EN`.
- Defined: in PUNISH, a round resolved with B=0 exits immediately to COOP, clears `sucker_cnt`, and zeroes `punish_cnt`. This takes effect regardless of the remaining count. ENDGAME/DONE overrides still take priority.
- Undefined: PUNISH always runs the full `PUNISH_LEN` rounds, ignoring B.

## Test plan
1. Defaults, B=0 every round, `round_valid`=1 continuously → A=0 for rounds 0–198 and A=1 for round 199. After round 199: `score`=602, `round_count`=200, `game_over`=1. Further valid cycles change nothing.
2. B=1 in round 0, then B=0 → round 0 pays 0, then A=1 from round 1 onward (win-stay). `score` after round 3 = 15.
3. B=1 every round, macro undefined → A sequence over rounds 0–6 is 0,1,0,1,1,1,0, with PUNISH on rounds 3–5. `score` after round 6 = 4.
4. Same stimulus as scenario 3, but with the macro defined and B=0 only in round 3 → round 3 pays 5. A=0 in round 4, and `sucker_cnt` is 0.
5. `round_valid`=0 for 10 cycles with B toggling → `score`, `round_count`, and `action_A` are unchanged.
6. Reset pulled low mid-cycle at `round_count`=50 with `score`≠0 → all outputs return to reset values before the next clock edge. After release, the game restarts from round 0 in COOP.
